// File: rtl/rom_copier.sv
// Copies LENGTH bytes from a synchronous ROM into SRAM at DEST_BASE, one byte per
// FETCH/LATCH/WRITE round. Define ROMCOPY_CHECKSUM_EN to build the running checksum.
module rom_copier #(
    parameter int          LENGTH    = 9216,
    parameter logic [20:0] DEST_BASE = 21'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [13:0] rom_a,
    input  logic [7:0]  rom_dout,
    output logic [20:0] sram_a,
    output logic [7:0]  sram_d,
    output logic        sram_we_req,
    input  logic        sram_ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, WRITE, DONE} state_t;

    localparam logic [13:0] LAST = 14'(LENGTH - 1);

    state_t      state, state_next;
    logic [13:0] index;
    logic        go, acked, last;

    assign go    = start && (state == IDLE || state == DONE);
    assign acked = (state == WRITE) && sram_ack;
    assign last  = (index == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = LATCH;
            LATCH:   state_next = WRITE;
            WRITE:   if (sram_ack) state_next = last ? DONE : FETCH;
            DONE:    if (start) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // rom_a is loaded on entry to FETCH so the ROM samples it on the FETCH->LATCH edge
    // and its data is ready to be captured on the LATCH->WRITE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index       <= '0;
            rom_a       <= '0;
            sram_a      <= '0;
            sram_d      <= '0;
            sram_we_req <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (go) begin
                index <= '0;
                rom_a <= '0;
                done  <= 1'b0;
                busy  <= 1'b1;
            end
            if (state == LATCH) begin
                sram_d      <= rom_dout;
                sram_a      <= DEST_BASE + {7'd0, index};
                sram_we_req <= 1'b1;
            end
            if (acked) begin
                sram_we_req <= 1'b0;
                if (last) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    index <= index + 14'd1;
                    rom_a <= index + 14'd1;
                end
            end
        end
    end

`ifdef ROMCOPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        checksum <= '0;
        else if (go)    checksum <= '0;
        else if (acked) checksum <= checksum + sram_d;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_copier.sv
// Scoreboard bench for rom_copier: main instance (LENGTH=4) plus LENGTH=1 and
// address-wrap instances sharing clock, reset and acknowledge.
module tb_rom_copier;

    typedef struct packed {
        logic [20:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ack = 1'b0;
    logic start_m = 1'b0, start_o = 1'b0, start_w = 1'b0;

    logic [13:0] rom_a_m, rom_a_o, rom_a_w;
    logic [7:0]  rom_dout_m, rom_dout_o, rom_dout_w;
    logic [20:0] sram_a_m, sram_a_o, sram_a_w;
    logic [7:0]  sram_d_m, sram_d_o, sram_d_w;
    logic        we_m, we_o, we_w;
    logic        busy_m, busy_o, busy_w;
    logic        done_m, done_o, done_w;
    logic [7:0]  checksum_m, checksum_o, checksum_w;

    logic [7:0] rom_m [4];
    wr_t q_m[$], q_o[$], q_w[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout_m <= (rom_a_m < 14'd4) ? rom_m[rom_a_m[1:0]] : 8'hEE;
    always @(posedge clk) rom_dout_o <= (rom_a_o == 14'd0) ? 8'h5A : 8'hEE;
    always @(posedge clk) rom_dout_w <= (rom_a_w == 14'd0) ? 8'hC1 :
                                        (rom_a_w == 14'd1) ? 8'hC2 : 8'hEE;

    rom_copier #(.LENGTH(4), .DEST_BASE(21'h000100)) u_main (
        .clk(clk), .rst(rst), .start(start_m), .rom_a(rom_a_m), .rom_dout(rom_dout_m),
        .sram_a(sram_a_m), .sram_d(sram_d_m), .sram_we_req(we_m), .sram_ack(ack),
        .busy(busy_m), .done(done_m), .checksum(checksum_m));

    rom_copier #(.LENGTH(1), .DEST_BASE(21'h000055)) u_one (
        .clk(clk), .rst(rst), .start(start_o), .rom_a(rom_a_o), .rom_dout(rom_dout_o),
        .sram_a(sram_a_o), .sram_d(sram_d_o), .sram_we_req(we_o), .sram_ack(ack),
        .busy(busy_o), .done(done_o), .checksum(checksum_o));

    rom_copier #(.LENGTH(2), .DEST_BASE(21'h1FFFFF)) u_wrap (
        .clk(clk), .rst(rst), .start(start_w), .rom_a(rom_a_w), .rom_dout(rom_dout_w),
        .sram_a(sram_a_w), .sram_d(sram_d_w), .sram_we_req(we_w), .sram_ack(ack),
        .busy(busy_w), .done(done_w), .checksum(checksum_w));

    function automatic logic [7:0] csum(input logic [7:0] s);
`ifdef ROMCOPY_CHECKSUM_EN
        return s;
`else
        return s & 8'h00;
`endif
    endfunction

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({we_m, busy_m, done_m, checksum_m, rom_a_m, sram_a_m, sram_d_m} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got we=%b busy=%b done=%b cs=%h rom_a=%h a=%h d=%h expected all zero",
                     we_m, busy_m, done_m, checksum_m, rom_a_m, sram_a_m, sram_d_m);
        end
        ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({we_m, busy_m, done_m} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got we=%b busy=%b done=%b expected 000", we_m, busy_m, done_m);
        end
    endtask

    // Runs one full copy on the main instance; optional ack stall on byte 2 and
    // optional start pulse while the first byte is in LATCH.
    task automatic do_copy(input int stall_n, input bit start_in_latch, input int exp_edges,
                           input string tag);
        logic [7:0] sum;
        int edges, bytes, stalled;
        wr_t e, got;
        sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            q_m.push_back('{a: 21'h100 + 21'(i), d: rom_m[i]});
            sum = sum + rom_m[i];
        end
        edges = 0; bytes = 0; stalled = 0;
        start_m = 1'b1;
        @(posedge clk);
        #1 start_m = 1'b0;
        n_cmp++;
        if (busy_m !== 1'b1 || done_m !== 1'b0 || checksum_m !== 8'h00) begin
            n_err++;
            $display("FAIL %s_start_state: got busy=%b done=%b cs=%h expected 1 0 00", tag, busy_m, done_m, checksum_m);
        end
        while (!done_m && edges < 200) begin
            start_m = start_in_latch && edges == 1;
            ack = 1'b1;
            if (we_m && bytes == 2 && stalled < stall_n) begin
                ack = 1'b0;
                stalled++;
                n_cmp++;
                if ({we_m, sram_a_m, sram_d_m} !== {1'b1, 21'h000102, rom_m[2]}) begin
                    n_err++;
                    $display("FAIL %s_stall_hold: got we=%b a=%h d=%h expected 1 000102 %h",
                             tag, we_m, sram_a_m, sram_d_m, rom_m[2]);
                end
            end
            if (we_m && ack) begin
                got = '{a: sram_a_m, d: sram_d_m};
                n_cmp++;
                if (q_m.size() == 0) begin
                    n_err++;
                    $display("FAIL %s_extra_write: got a=%h d=%h expected no write", tag, got.a, got.d);
                end else begin
                    e = q_m.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL %s_write: got a=%h d=%h expected a=%h d=%h", tag, got.a, got.d, e.a, e.d);
                    end
                end
                bytes++;
            end
            @(posedge clk);
            #1 edges++;
        end
        start_m = 1'b0;
        n_cmp++;
        if (edges !== exp_edges) begin
            n_err++;
            $display("FAIL %s_latency: got %0d clocks expected %0d", tag, edges, exp_edges);
        end
        n_cmp++;
        if (done_m !== 1'b1 || busy_m !== 1'b0 || we_m !== 1'b0) begin
            n_err++;
            $display("FAIL %s_end_flags: got done=%b busy=%b we=%b expected 1 0 0", tag, done_m, busy_m, we_m);
        end
        n_cmp++;
        if (checksum_m !== csum(sum)) begin
            n_err++;
            $display("FAIL %s_checksum: got %h expected %h", tag, checksum_m, csum(sum));
        end
        n_cmp++;
        if (bytes != 4 || q_m.size() != 0) begin
            n_err++;
            $display("FAIL %s_write_count: got %0d writes, %0d left expected 4, 0", tag, bytes, q_m.size());
        end
        q_m.delete();
    endtask

    task automatic test_basic();
        do_copy(0, 1'b0, 12, "basic");
    endtask

    task automatic test_restart();
        do_copy(0, 1'b0, 12, "restart");
    endtask

    task automatic test_stall();
        do_copy(5, 1'b0, 17, "stall");
    endtask

    task automatic test_ignored_start();
        do_copy(0, 1'b1, 12, "latch_start");
    endtask

    task automatic test_reset_mid();
        int edges, bytes;
        edges = 0; bytes = 0;
        start_m = 1'b1;
        @(posedge clk);
        #1 start_m = 1'b0;
        while (!(we_m && bytes == 1) && edges < 50) begin
            ack = 1'b1;
            if (we_m) bytes++;
            @(posedge clk);
            #1 edges++;
        end
        n_cmp++;
        if (edges >= 50) begin
            n_err++;
            $display("FAIL mid_reach_write: got timeout after %0d clocks expected WRITE of byte 1", edges);
        end
        ack = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({we_m, busy_m, done_m, checksum_m, rom_a_m, sram_a_m, sram_d_m} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_async: got we=%b busy=%b done=%b cs=%h rom_a=%h a=%h d=%h expected all zero",
                     we_m, busy_m, done_m, checksum_m, rom_a_m, sram_a_m, sram_d_m);
        end
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_copy(0, 1'b0, 12, "after_reset");
    endtask

    task automatic test_boundaries();
        int wo, ww, d_o, d_w;
        wr_t e;
        wo = 0; ww = 0; d_o = -1; d_w = -1;
        q_o.push_back('{a: 21'h000055, d: 8'h5A});
        q_w.push_back('{a: 21'h1FFFFF, d: 8'hC1});
        q_w.push_back('{a: 21'h000000, d: 8'hC2});
        ack = 1'b1;
        start_o = 1'b1;
        start_w = 1'b1;
        @(posedge clk);
        #1 start_o = 1'b0;
        start_w = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done_o && d_o < 0) d_o = c;
            if (done_w && d_w < 0) d_w = c;
            if (we_o) begin
                n_cmp++;
                e = (q_o.size() != 0) ? q_o.pop_front() : '0;
                if ({sram_a_o, sram_d_o} !== e) begin
                    n_err++;
                    $display("FAIL len1_write: got a=%h d=%h expected a=%h d=%h", sram_a_o, sram_d_o, e.a, e.d);
                end
                wo++;
            end
            if (we_w) begin
                n_cmp++;
                e = (q_w.size() != 0) ? q_w.pop_front() : '0;
                if ({sram_a_w, sram_d_w} !== e) begin
                    n_err++;
                    $display("FAIL wrap_write: got a=%h d=%h expected a=%h d=%h", sram_a_w, sram_d_w, e.a, e.d);
                end
                ww++;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (wo != 1 || d_o != 3 || busy_o !== 1'b0 || checksum_o !== csum(8'h5A)) begin
            n_err++;
            $display("FAIL len1_summary: got writes=%0d done_at=%0d busy=%b cs=%h expected 1 3 0 %h",
                     wo, d_o, busy_o, checksum_o, csum(8'h5A));
        end
        n_cmp++;
        if (ww != 2 || d_w != 6 || busy_w !== 1'b0 || checksum_w !== csum(8'h83)) begin
            n_err++;
            $display("FAIL wrap_summary: got writes=%0d done_at=%0d busy=%b cs=%h expected 2 6 0 %h",
                     ww, d_w, busy_w, checksum_w, csum(8'h83));
        end
    endtask

    initial begin
        rom_m[0] = 8'h11;
        rom_m[1] = 8'h22;
        rom_m[2] = 8'h33;
        rom_m[3] = 8'h44;
        test_reset();
        test_basic();
        test_restart();
        test_stall();
        test_ignored_start();
        test_reset_mid();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
